cpu_reg_bank: RTL and testbench

Parametrised CPU-writable register bank: NUM_REGS registers of DATA_W bits, written and read through a simple address/strobe bus from the host CPU interface. It is the successor of the fixed three-register, chip-select write block and adds address decoding, edge-qualified strobes, registered readback, per-register update pulses and out-of-range error reporting. It sits between the CPU bus front end and the datapath blocks that consume configuration registers.

---
 rtl/cpu_reg_bank.sv | 87 ++++++++
 tb/tb_cpu_reg_bank.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_reg_bank.sv
// CPU-writable register bank: edge-qualified write/read strobes, registered
// readback, per-register update pulses and out-of-range error reporting.
module cpu_reg_bank #(
  parameter int                 DATA_W    = 8,
  parameter int                 NUM_REGS  = 4,
  parameter int                 ADDR_W    = 2,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         wr_req,
  input  logic                         rd_req,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         wr_ack,
  output logic                         rd_ack,
  output logic [NUM_REGS-1:0]          upd,
  output logic                         addr_err
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0]               rd_data_q, rd_data_d;
  logic [NUM_REGS-1:0]             upd_q, upd_d;
  logic                            wr_ack_q, wr_ack_d;
  logic                            rd_ack_q, rd_ack_d;
  logic                            err_q, err_d;
  logic                            wr_hist_q, rd_hist_q;

  logic wr_fire, rd_fire, in_range, wr_ok;

  // History flops reset high so a strobe held through reset release is ignored.
  assign wr_fire  = wr_req & ~wr_hist_q;
  assign rd_fire  = rd_req & ~rd_hist_q;
  assign in_range = ({1'b0, addr} < (ADDR_W+1)'(NUM_REGS));
  assign wr_ok    = wr_fire & in_range;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic hit;
    assign hit       = wr_ok & (addr == ADDR_W'(g));
    assign upd_d[g]  = hit;
    assign regs_d[g] = hit ? data_in : regs_q[g];
  end

  always_comb begin
    rd_data_d = rd_data_q;
    wr_ack_d  = wr_ok;
    rd_ack_d  = 1'b0;
    err_d     = (wr_fire | rd_fire) & ~in_range;
    // Readback uses regs_q, so a same-cycle write to the same index returns the old value.
    if (rd_fire && in_range) begin
      rd_data_d = regs_q[addr];
      rd_ack_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q    <= {NUM_REGS{RESET_VAL}};
      rd_data_q <= '0;
      upd_q     <= '0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      err_q     <= 1'b0;
      wr_hist_q <= 1'b1;
      rd_hist_q <= 1'b1;
    end else begin
      regs_q    <= regs_d;
      rd_data_q <= rd_data_d;
      upd_q     <= upd_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      err_q     <= err_d;
      wr_hist_q <= wr_req;
      rd_hist_q <= rd_req;
    end
  end

  assign regs_out = regs_q;
  assign rd_data  = rd_data_q;
  assign upd      = upd_q;
  assign wr_ack   = wr_ack_q;
  assign rd_ack   = rd_ack_q;
  assign addr_err = err_q;

endmodule

// File: tb/tb_cpu_reg_bank.sv
// Directed bench for cpu_reg_bank: a per-cycle vector table on a 4-register
// instance plus hand sequences for reset corners and a 3-register instance.
module tb_cpu_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr, addr3;
  logic [7:0]  data_in, data3;
  logic        wr_req, rd_req, wr3, rd3;
  logic [31:0] regs_out;
  logic [23:0] regs_out3;
  logic [7:0]  rd_data, rd_data3;
  logic        wr_ack, rd_ack, addr_err, wr_ack3, rd_ack3, addr_err3;
  logic [3:0]  upd;
  logic [2:0]  upd3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_reg_bank #(.DATA_W(8), .NUM_REGS(4), .ADDR_W(2), .RESET_VAL(8'h00)) u4 (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr_req(wr_req),
    .rd_req(rd_req), .regs_out(regs_out), .rd_data(rd_data), .wr_ack(wr_ack),
    .rd_ack(rd_ack), .upd(upd), .addr_err(addr_err));

  cpu_reg_bank #(.DATA_W(8), .NUM_REGS(3), .ADDR_W(2), .RESET_VAL(8'h00)) u3 (
    .clk(clk), .rst(rst), .addr(addr3), .data_in(data3), .wr_req(wr3),
    .rd_req(rd3), .regs_out(regs_out3), .rd_data(rd_data3), .wr_ack(wr_ack3),
    .rd_ack(rd_ack3), .upd(upd3), .addr_err(addr_err3));

  typedef struct {
    logic        wr, rd;
    logic [1:0]  a;
    logic [7:0]  d;
    logic [31:0] e_regs;
    logic [7:0]  e_rd;
    logic        e_wack, e_rack;
    logic [3:0]  e_upd;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic wr, input logic rd, input logic [1:0] a,
                      input logic [7:0] d, input logic [31:0] er, input logic [7:0] erd,
                      input logic ew, input logic era, input logic [3:0] eu);
    vec_t v;
    v.wr = wr; v.rd = rd; v.a = a; v.d = d; v.e_regs = er; v.e_rd = erd;
    v.e_wack = ew; v.e_rack = era; v.e_upd = eu; v.e_err = 1'b0;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; addr = '0; data_in = '0; wr_req = 1'b0; rd_req = 1'b0;
    addr3 = '0; data3 = '0; wr3 = 1'b0; rd3 = 1'b0;

    //    wr rd a  data   regs          rd     wack rack upd
    addv(0, 0, 0, 8'h00, 32'h00000000, 8'h00, 0, 0, 4'b0000);
    addv(1, 0, 2, 8'hA5, 32'h00A50000, 8'h00, 1, 0, 4'b0100);
    for (int i = 0; i < 4; i++)
      addv(1, 0, 2, 8'hA5, 32'h00A50000, 8'h00, 0, 0, 4'b0000);
    addv(0, 0, 2, 8'h00, 32'h00A50000, 8'h00, 0, 0, 4'b0000);
    addv(0, 1, 2, 8'h00, 32'h00A50000, 8'hA5, 0, 1, 4'b0000);
    for (int i = 0; i < 4; i++)
      addv(0, 1, 2, 8'h00, 32'h00A50000, 8'hA5, 0, 0, 4'b0000);
    addv(0, 0, 2, 8'h00, 32'h00A50000, 8'hA5, 0, 0, 4'b0000);
    addv(1, 1, 2, 8'h5A, 32'h005A0000, 8'hA5, 1, 1, 4'b0100);
    addv(0, 0, 2, 8'h00, 32'h005A0000, 8'hA5, 0, 0, 4'b0000);
    addv(1, 0, 0, 8'h11, 32'h005A0011, 8'hA5, 1, 0, 4'b0001);
    addv(0, 0, 0, 8'h00, 32'h005A0011, 8'hA5, 0, 0, 4'b0000);
    addv(1, 0, 3, 8'hFF, 32'hFF5A0011, 8'hA5, 1, 0, 4'b1000);
    addv(0, 0, 3, 8'h00, 32'hFF5A0011, 8'hA5, 0, 0, 4'b0000);
    addv(1, 0, 3, 8'hFF, 32'hFF5A0011, 8'hA5, 1, 0, 4'b1000);
    addv(0, 0, 0, 8'h00, 32'hFF5A0011, 8'hA5, 0, 0, 4'b0000);
    addv(0, 1, 0, 8'h00, 32'hFF5A0011, 8'h11, 0, 1, 4'b0000);
    addv(0, 0, 0, 8'h00, 32'hFF5A0011, 8'h11, 0, 0, 4'b0000);
    addv(0, 1, 3, 8'h00, 32'hFF5A0011, 8'hFF, 0, 1, 4'b0000);
    addv(0, 0, 0, 8'h00, 32'hFF5A0011, 8'hFF, 0, 0, 4'b0000);
    addv(1, 0, 1, 8'h22, 32'hFF5A2211, 8'hFF, 1, 0, 4'b0010);
    addv(0, 0, 1, 8'h00, 32'hFF5A2211, 8'hFF, 0, 0, 4'b0000);
    addv(1, 0, 1, 8'h33, 32'hFF5A3311, 8'hFF, 1, 0, 4'b0010);
    addv(0, 0, 0, 8'h00, 32'hFF5A3311, 8'hFF, 0, 0, 4'b0000);

    #12;
    check("rst regs", regs_out, 32'h0);
    check("rst rd_data", {24'h0, rd_data}, 32'h0);
    check("rst acks", {28'h0, wr_ack, rd_ack, addr_err, 1'b0}, 32'h0);
    check("rst upd", {28'h0, upd}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      wr_req = vq[i].wr; rd_req = vq[i].rd; addr = vq[i].a; data_in = vq[i].d;
      tick();
      check($sformatf("v%0d regs", i), regs_out, vq[i].e_regs);
      check($sformatf("v%0d rd_data", i), {24'h0, rd_data}, {24'h0, vq[i].e_rd});
      check($sformatf("v%0d wr_ack", i), {31'h0, wr_ack}, {31'h0, vq[i].e_wack});
      check($sformatf("v%0d rd_ack", i), {31'h0, rd_ack}, {31'h0, vq[i].e_rack});
      check($sformatf("v%0d upd", i), {28'h0, upd}, {28'h0, vq[i].e_upd});
      check($sformatf("v%0d addr_err", i), {31'h0, addr_err}, {31'h0, vq[i].e_err});
    end

    // 3-register instance: index 3 is out of range
    addr3 = 2'd3; data3 = 8'h77; wr3 = 1'b1;
    tick();
    check("oor wr err", {31'h0, addr_err3}, 32'h1);
    check("oor wr ack", {31'h0, wr_ack3}, 32'h0);
    check("oor wr upd", {29'h0, upd3}, 32'h0);
    check("oor wr regs", {8'h0, regs_out3}, 32'h0);
    wr3 = 1'b0;
    tick();
    check("oor err pulse", {31'h0, addr_err3}, 32'h0);
    addr3 = 2'd1; data3 = 8'h44; wr3 = 1'b1;
    tick();
    check("u3 wr regs", {8'h0, regs_out3}, 32'h00004400);
    check("u3 wr upd", {29'h0, upd3}, 32'h2);
    wr3 = 1'b0;
    tick();
    rd3 = 1'b1;
    tick();
    check("u3 rd data", {24'h0, rd_data3}, 32'h44);
    check("u3 rd ack", {31'h0, rd_ack3}, 32'h1);
    rd3 = 1'b0;
    tick();
    addr3 = 2'd3; rd3 = 1'b1;
    tick();
    check("oor rd err", {31'h0, addr_err3}, 32'h1);
    check("oor rd ack", {31'h0, rd_ack3}, 32'h0);
    check("oor rd data", {24'h0, rd_data3}, 32'h44);
    rd3 = 1'b0;
    tick();

    // reset asserted while wr_ack is high
    addr = 2'd0; data_in = 8'hAB; wr_req = 1'b1;
    tick();
    check("pre-rst wr_ack", {31'h0, wr_ack}, 32'h1);
    check("pre-rst regs", regs_out, 32'hFF5A33AB);
    rst = 1'b1;
    #1;
    check("mid rst regs", regs_out, 32'h0);
    check("mid rst wr_ack", {31'h0, wr_ack}, 32'h0);
    check("mid rst upd", {28'h0, upd}, 32'h0);

    // strobe held through reset release is ignored
    addr = 2'd1; data_in = 8'h3C; wr_req = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("held wr regs", regs_out, 32'h0);
    check("held wr ack", {31'h0, wr_ack}, 32'h0);
    tick();
    check("held wr regs2", regs_out, 32'h0);
    wr_req = 1'b0;
    tick();
    wr_req = 1'b1;
    tick();
    check("rearm regs", regs_out, 32'h00003C00);
    check("rearm ack", {31'h0, wr_ack}, 32'h1);
    wr_req = 1'b0;
    tick();
    check("rearm ack drop", {31'h0, wr_ack}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
